// File: rtl/key_state_decoder.sv
// PS/2 scan-code decoder: turns make/break byte sequences into four held
// movement levels (arrow keys, optionally aliased by W/A/S/D).
module key_state_decoder #(
    parameter bit          ENABLE_WASD    = 1'b1,
    parameter logic [31:0] PREFIX_TIMEOUT = 32'd500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       turn_right,
    output logic       turn_left,
    output logic       move_forward,
    output logic       move_backward,
    output logic       key_event
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_EXT        = 3'd1,
        S_BREAK      = 3'd2,
        S_EXT_BREAK  = 3'd3,
        S_PAUSE_SKIP = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  skip_cnt;
    logic [31:0] timeout_cnt;

    // Bit order everywhere: 0 right, 1 left, 2 forward, 3 backward.
    logic [3:0] arrow_bits;
    logic [3:0] wasd_bits;
    logic [3:0] arrow_next;
    logic [3:0] wasd_next;
    logic [3:0] arrow_hit;
    logic [3:0] wasd_hit;
    logic [3:0] out_vec;
    logic [3:0] out_next;

    always_comb begin
        arrow_hit = 4'b0000;
        case (byte_in)
            8'h74:   arrow_hit = 4'b0001;
            8'h6B:   arrow_hit = 4'b0010;
            8'h75:   arrow_hit = 4'b0100;
            8'h72:   arrow_hit = 4'b1000;
            default: arrow_hit = 4'b0000;
        endcase
        wasd_hit = 4'b0000;
        case (byte_in)
            8'h23:   wasd_hit = 4'b0001;
            8'h1C:   wasd_hit = 4'b0010;
            8'h1D:   wasd_hit = 4'b0100;
            8'h1B:   wasd_hit = 4'b1000;
            default: wasd_hit = 4'b0000;
        endcase
        wasd_hit = wasd_hit & {4{ENABLE_WASD}};
    end

    always_comb begin
        arrow_next = arrow_bits;
        wasd_next  = wasd_bits;
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_in == 8'hAA) begin
                        arrow_next = 4'b0000;
                        wasd_next  = 4'b0000;
                    end else begin
                        wasd_next = wasd_bits | wasd_hit;
                    end
                end
                S_EXT:       arrow_next = arrow_bits | arrow_hit;
                S_BREAK:     wasd_next  = wasd_bits & ~wasd_hit;
                S_EXT_BREAK: arrow_next = arrow_bits & ~arrow_hit;
                default: begin
                    arrow_next = arrow_bits;
                    wasd_next  = wasd_bits;
                end
            endcase
        end
        out_next = arrow_next | wasd_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            skip_cnt    <= 3'd0;
            timeout_cnt <= 32'd0;
            arrow_bits  <= 4'b0000;
            wasd_bits   <= 4'b0000;
            out_vec     <= 4'b0000;
            key_event   <= 1'b0;
        end else begin
            arrow_bits <= arrow_next;
            wasd_bits  <= wasd_next;
            out_vec    <= out_next;
            key_event  <= (out_next != out_vec);
            if (byte_valid) begin
                timeout_cnt <= 32'd0;
                case (state)
                    S_IDLE: begin
                        case (byte_in)
                            8'hE0:   state <= S_EXT;
                            8'hF0:   state <= S_BREAK;
                            8'hE1: begin
                                state    <= S_PAUSE_SKIP;
                                skip_cnt <= 3'd7;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                    S_EXT:   state <= (byte_in == 8'hF0) ? S_EXT_BREAK : S_IDLE;
                    S_PAUSE_SKIP: begin
                        skip_cnt <= skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                // The counter would reach PREFIX_TIMEOUT on this edge: abandon
                // the partial sequence and clear it instead of storing that value.
                if (timeout_cnt == PREFIX_TIMEOUT - 32'd1) begin
                    state       <= S_IDLE;
                    timeout_cnt <= 32'd0;
                end else begin
                    timeout_cnt <= timeout_cnt + 32'd1;
                end
            end else begin
                timeout_cnt <= 32'd0;
            end
        end
    end

    assign turn_right    = out_vec[0];
    assign turn_left     = out_vec[1];
    assign move_forward  = out_vec[2];
    assign move_backward = out_vec[3];

endmodule

// File: tb/tb_key_state_decoder.sv
// Bench for key_state_decoder: two instances (WASD on / off) driven by the
// same byte stream, checked every cycle against a prefix-queue reference model.
module tb_key_state_decoder;

    localparam logic [31:0] T = 32'd40;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       w_right, w_left, w_fwd, w_bwd, w_ev;
    logic       n_right, n_left, n_fwd, n_bwd, n_ev;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] exp_q[$];

    // ---------------- clock / DUTs ----------------
    always #5 clock = ~clock;

    key_state_decoder #(.ENABLE_WASD(1'b1), .PREFIX_TIMEOUT(T)) dut_w (
        .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .turn_right(w_right), .turn_left(w_left), .move_forward(w_fwd),
        .move_backward(w_bwd), .key_event(w_ev)
    );

    key_state_decoder #(.ENABLE_WASD(1'b0), .PREFIX_TIMEOUT(T)) dut_n (
        .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .turn_right(n_right), .turn_left(n_left), .move_forward(n_fwd),
        .move_backward(n_bwd), .key_event(n_ev)
    );

    // ---------------- reference model ----------------
    // Index 0 = WASD enabled instance, 1 = WASD disabled instance.
    logic [3:0] arrow_h[2];
    logic [3:0] wasd_h[2];
    logic [7:0] pend[$];
    int         pause_left = 0;
    int         gap = 0;

    function automatic int arrow_index(input logic [7:0] b);
        case (b)
            8'h74: return 0;
            8'h6B: return 1;
            8'h75: return 2;
            8'h72: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int wasd_index(input logic [7:0] b);
        case (b)
            8'h23: return 0;
            8'h1C: return 1;
            8'h1D: return 2;
            8'h1B: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (pause_left > 0) begin
            pause_left--;
        end else if (pend.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
            else if (b == 8'hE1) pause_left = 7;
            else if (b == 8'hAA) begin
                arrow_h[0] = 0; arrow_h[1] = 0; wasd_h[0] = 0; wasd_h[1] = 0;
            end else begin
                k = wasd_index(b);
                if (k >= 0) wasd_h[0][k] = 1'b1;
            end
        end else if (pend.size() == 1 && pend[0] == 8'hE0) begin
            if (b == 8'hF0) pend.push_back(b);
            else begin
                k = arrow_index(b);
                if (k >= 0) begin
                    arrow_h[0][k] = 1'b1;
                    arrow_h[1][k] = 1'b1;
                end
                pend.delete();
            end
        end else if (pend.size() == 1) begin
            k = wasd_index(b);
            if (k >= 0) begin
                wasd_h[0][k] = 1'b0;
                wasd_h[1][k] = 1'b0;
            end
            pend.delete();
        end else begin
            k = arrow_index(b);
            if (k >= 0) begin
                arrow_h[0][k] = 1'b0;
                arrow_h[1][k] = 1'b0;
            end
            pend.delete();
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input logic [7:0] b,
                              output logic [9:0] e);
        logic [3:0] b0, b1, a0, a1;
        if (!rst) begin
            arrow_h[0] = 0; arrow_h[1] = 0; wasd_h[0] = 0; wasd_h[1] = 0;
            pend.delete();
            pause_left = 0;
            gap = 0;
            e = '0;
        end else begin
            b0 = arrow_h[0] | wasd_h[0];
            b1 = arrow_h[1] | wasd_h[1];
            if (v) begin
                gap = 0;
                model_byte(b);
            end else if (pend.size() > 0 || pause_left > 0) begin
                gap++;
                if (gap == int'(T)) begin
                    pend.delete();
                    pause_left = 0;
                    gap = 0;
                end
            end else begin
                gap = 0;
            end
            a0 = arrow_h[0] | wasd_h[0];
            a1 = arrow_h[1] | wasd_h[1];
            e = {(a1 != b1), a1, (a0 != b0), a0};
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit rst, input bit v, input logic [7:0] b);
        logic [9:0] e;
        @(negedge clock);
        #1;
        reset      = rst;
        byte_valid = v;
        byte_in    = v ? b : 8'h00;
        model_step(rst, v, b, e);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_seq(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                            input int len);
        send(s0);
        if (len > 1) send(s1);
        if (len > 2) send(s2);
        idle(1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [9:0] got;
        logic [9:0] want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {n_ev, n_bwd, n_fwd, n_left, n_right, w_ev, w_bwd, w_fwd, w_left, w_right};
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL outputs @%0t: got %b required %b (n_ev,n_vec,w_ev,w_vec)",
                         $time, got, want);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pool [17];

    initial begin
        int r;
        pool = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h74, 8'h6B, 8'h75, 8'h72, 8'h23,
                 8'h1C, 8'h1D, 8'h1B, 8'h12, 8'h59, 8'h00, 8'h14, 8'h77};

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
        idle(2);

        // Extended make, long idle, extended break.
        send_seq(8'hE0, 8'h75, 8'h00, 2);
        idle(100);
        send_seq(8'hE0, 8'hF0, 8'h75, 3);

        // WASD make with typematic repeats, then break.
        send(8'h1D);
        for (int i = 0; i < 5; i++) send(8'h1D);
        send_seq(8'hF0, 8'h1D, 8'h00, 2);

        // Two aliases held; releasing one keeps the output.
        send_seq(8'hE0, 8'h74, 8'h00, 2);
        send(8'h23);
        send_seq(8'hF0, 8'h23, 8'h00, 2);
        send_seq(8'hE0, 8'hF0, 8'h74, 3);

        // Pause sequence then a real key.
        send(8'hE1);
        send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
        send(8'h14); send(8'hF0); send(8'h77);
        send_seq(8'hE0, 8'h6B, 8'h00, 2);

        // Self-test byte clears everything.
        send(8'hAA);
        idle(2);

        // Timeout boundary: one cycle short still extended, full timeout abandons.
        send(8'hE0); idle(int'(T) - 1); send(8'h75); idle(2);
        send_seq(8'hE0, 8'hF0, 8'h75, 3);
        send(8'hE0); idle(int'(T)); send(8'h75); idle(2);

        // Reset in the middle of a break sequence.
        send_seq(8'hE0, 8'h72, 8'h00, 2);
        send(8'h1C);
        send(8'hE0); send(8'hF0);
        drive(1'b0, 1'b0, 8'h00);
        send(8'h72);
        idle(2);

        // Randomized byte stream.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) drive(1'b0, 1'b0, 8'h00);
            else if (r < 6) idle(int'(T) - 1 + $urandom_range(0, 2));
            else if (r < 40) idle($urandom_range(1, 3));
            send(pool[$urandom_range(0, 16)]);
        end
        idle(3);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/key_state_decoder.md
Name: key_state_decoder

Overview:
- Converts the byte stream from the PS/2 keyboard receiver into four held key levels: turn_right, turn_left, move_forward, move_backward.
- These levels feed the player update stage directly.
- Tracks make/break codes, the E0 extended prefix, the E1 pause sequence and the keyboard self-test byte.
- Each output stays high for as long as its key is physically held.

Parameters:
ENABLE_WASD, 1, when 1 the W/A/S/D make/break codes also drive the outputs, in addition to the arrow keys
PREFIX_TIMEOUT, 32'd500000, clock cycles allowed between prefix bytes before a partial sequence is abandoned (10 ms at 50 MHz)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 clears on the next posedge)
byte_in  input  8  received scan-code byte
byte_valid  input  1  byte_in is valid this cycle; one byte consumed per cycle asserted
turn_right  output  1  right arrow (or D) held
turn_left  output  1  left arrow (or A) held
move_forward  output  1  up arrow (or W) held
move_backward  output  1  down arrow (or S) held
key_event  output  1  one-cycle pulse when any of the four outputs changed value

Behaviour:
- Key codes:
  - Arrows, always preceded by E0: up 75, down 72, left 6B, right 74.
  - WASD, non-extended: W 1D, S 1B, A 1C, D 23.
- Key state registers:
  - Eight internal held bits: four arrow bits and four WASD bits.
  - Each output = arrow bit OR WASD bit, so releasing one of two held aliases leaves the output high.
  - When ENABLE_WASD=0, the WASD bits are never set.
- Reset (reset==0): state=IDLE, all key bits 0, all outputs 0, key_event 0, timeout counter 0, skip counter 0. Reset mid-sequence discards any partial sequence.
- FSM states: IDLE, EXT, BREAK, EXT_BREAK, PAUSE_SKIP. Transitions occur only on cycles with byte_valid=1, except for the timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BREAK.
  - E1 -> PAUSE_SKIP, skip counter loaded with 7.
  - AA (self-test pass) -> clear all eight key bits, stay IDLE.
  - WASD code -> set that bit, stay IDLE.
  - Any other byte -> ignored, stay IDLE.
- EXT:
  - F0 -> EXT_BREAK.
  - Arrow code -> set arrow bit, go to IDLE.
  - Any other byte (incl. fake-shift 12/59) -> ignored, go to IDLE.
- BREAK: WASD code -> clear that bit, go to IDLE. Any other byte -> go to IDLE.
- EXT_BREAK: arrow code -> clear that bit, go to IDLE. Any other byte -> go to IDLE.
- PAUSE_SKIP:
  - Each valid byte decrements the skip counter, with no key effect.
  - When the counter is 1 on a valid byte, go to IDLE, so exactly 7 bytes are skipped after E1.
- Timeout (applies in every state other than IDLE):
  - A 32-bit counter increments each cycle with byte_valid=0 and clears on any byte_valid.
  - When it reaches PREFIX_TIMEOUT, go to IDLE and clear the counter. No key bits change.
  - In IDLE the counter is held at 0.
- Latency: the byte sampled at posedge N updates the key bits at that edge, so the outputs reflect it during cycle N+1.
- key_event is registered:
  - It is high in cycle N+1 only if the output vector after edge N differs from the vector before it.
  - Typematic repeat makes (bit already set) and duplicate breaks produce no pulse.
- byte_valid held for consecutive cycles is treated as consecutive bytes; the upstream receiver pulses it for one cycle per byte.
- Multiple outputs may be high at once. This block does not resolve conflicts; the consumer treats non-one-hot input as no movement.

Test Plan:
- Bytes E0,75, then after 100 idle cycles E0,F0,75 -> move_forward rises 1 cycle after byte 75 and falls 1 cycle after the final 75; key_event pulses exactly twice.
- Byte 1D, then 1D repeated 5 times, then F0,1D (ENABLE_WASD=1) -> move_forward high after the first 1D and low after the final 1D; key_event pulses only twice. With ENABLE_WASD=0 the same stimulus leaves all outputs 0.
- Hold E0,74 and 23 together, then release D (F0,23) -> turn_right stays 1. Then E0,F0,74 -> turn_right drops to 0.
- E1,14,77,E1,F0,14,F0,77, then E0,6B -> the 7 pause bytes cause no output change; turn_left rises after 6B.
- Byte E0 alone, wait PREFIX_TIMEOUT cycles, then 75 -> FSM back in IDLE; 75 is treated as non-extended and ignored; move_forward stays 0.
- With turn_left high: byte AA clears all outputs with a key_event pulse. Separately, with keys held, driving reset=0 for 1 cycle mid-sequence (after E0,F0) clears all outputs; a following 75 has no effect.
